// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable tick generator.
//
// Each of NCH channels divides clk by its own run-time reloadable divisor.
// Each channel produces a one-cycle tick per period and a 50% square wave
// that toggles on every tick.
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   en       in   [NCH]  per-channel count enable (low = hold, phase kept)
//   clr      in   synchronous restart of all counters, ticks and squares
//   wr_en    in   divisor write strobe
//   wr_ch    in   [CW]   channel index for the write
//   wr_div   in   [W]    new divisor (period in clk cycles, >= 2)
//   tick     out  [NCH]  registered one-cycle pulse per channel period
//   sq       out  [NCH]  registered square wave, period 2*div
//   wr_err   out  registered one-cycle pulse for a rejected write
//
// Write interface: wr_en is a single-cycle strobe with no back-pressure.
// A write is accepted on the edge that samples wr_en=1 when wr_ch < NCH
// and wr_div >= 2; otherwise it is dropped and wr_err pulses on that same
// edge. There is no ready signal: every strobe is either taken or flagged.
//
// Per-edge priority, highest first: clr, divisor write, count. A divisor
// write and clr on the same edge both take effect.
module tick_gen #(
    parameter int NCH = 3,
    parameter int W   = 32,
    parameter logic [NCH*W-1:0] DIV_INIT =
        {32'd100_000, 32'd50_000_000, 32'd100_000_000},
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [NCH-1:0] en,
    input  logic           clr,
    input  logic           wr_en,
    input  logic [CW-1:0]  wr_ch,
    input  logic [W-1:0]   wr_div,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic           wr_err
);

    // One extra bit so NCH itself is representable (e.g. NCH=8, CW=3).
    localparam logic [CW:0]  NCH_L   = (CW+1)'(NCH);
    localparam logic [W-1:0] DIV_MIN = W'(2);
    localparam logic [W-1:0] ONE     = W'(1);

    logic wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_ch} < NCH_L) && (wr_div >= DIV_MIN);

    // Rejected-write flag. clr does not suppress it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [W-1:0] div_q;
        logic [W-1:0] cnt_q;
        logic         tick_q;
        logic         sq_q;
        logic         sel;
        logic         term;

        assign sel  = wr_ok && (wr_ch == CW'(i));
        // cnt_q is kept in 0..div_q-1 and div_q >= 2, so div_q-1 never wraps.
        assign term = (cnt_q == (div_q - ONE));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                div_q  <= DIV_INIT[i*W +: W];
                cnt_q  <= '0;
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
            end else begin
                // The divisor is loaded even when clr is also asserted.
                if (sel) begin
                    div_q <= wr_div;
                end

                if (clr) begin
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                    sq_q   <= 1'b0;
                end else if (sel) begin
                    // A reload restarts the period and swallows a tick that
                    // would otherwise fall on this edge; sq keeps its level.
                    cnt_q  <= '0;
                    tick_q <= 1'b0;
                end else if (en[i]) begin
                    if (term) begin
                        cnt_q  <= '0;
                        tick_q <= 1'b1;
                        sq_q   <= ~sq_q;
                    end else begin
                        cnt_q  <= cnt_q + ONE;
                        tick_q <= 1'b0;
                    end
                end else begin
                    // Hold: count and square wave frozen, phase preserved.
                    tick_q <= 1'b0;
                end
            end
        end

        assign tick[i] = tick_q;
        assign sq[i]   = sq_q;
    end

endmodule

// File: tb/tb_tick_gen.sv
// Testbench for tick_gen with NCH=3, W=8, divisors ch0=2, ch1=3, ch2=5.
// Free-running phases are checked against closed-form tick/sq patterns;
// write, invalid-write and clr sequences are checked from a table of
// hand-computed vectors; async reset is checked between edges.
module tb_tick_gen;

    localparam int NCH = 3;
    localparam int W   = 8;

    logic           clk;
    logic           reset_n;
    logic [NCH-1:0] en;
    logic           clr;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [W-1:0]   wr_div;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;
    logic           wr_err;

    int checks   = 0;
    int failures = 0;

    tick_gen #(
        .NCH     (NCH),
        .W       (W),
        .DIV_INIT({8'd5, 8'd3, 8'd2})
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .tick    (tick),
        .sq      (sq),
        .wr_err  (wr_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input int n,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", name, n, got, exp);
        end
    endtask

    // Free-running pattern for a channel that started at cnt=0 with divisor d:
    // after edge n it has ticked iff n%d==0, and sq = parity of ticks so far.
    function automatic logic ftick(input int n, input int d);
        return (n % d) == 0;
    endfunction

    function automatic logic fsq(input int n, input int d);
        return ((n / d) % 2) == 1;
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        int         edge_n;
        logic [2:0] en;
        logic       clr;
        logic       wr_en;
        logic [1:0] wr_ch;
        logic [7:0] wr_div;
        logic [2:0] tick;   // {ch2, ch1, ch0}
        logic [2:0] sq;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int e, input logic [2:0] v_en, input logic v_clr,
                       input logic v_wr, input logic [1:0] v_ch,
                       input logic [7:0] v_div, input logic [2:0] v_tick,
                       input logic [2:0] v_sq, input logic v_err);
        vec_t v;
        v.edge_n = e;   v.en = v_en;   v.clr = v_clr;
        v.wr_en = v_wr; v.wr_ch = v_ch; v.wr_div = v_div;
        v.tick = v_tick; v.sq = v_sq;  v.err = v_err;
        tbl.push_back(v);
    endtask

    task automatic drive_idle();
        clr    = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = 2'd0;
        wr_div = 8'd0;
    endtask

    // Free-running run from reset release: edges first..last, all enabled.
    task automatic run_free(input int first, input int last, input string tag);
        for (int n = first; n <= last; n++) begin
            @(posedge clk);
            #1;
            check({tag, "_tick"}, n, {29'd0, tick},
                  {29'd0, ftick(n, 5), ftick(n, 3), ftick(n, 2)});
            check({tag, "_sq"}, n, {29'd0, sq},
                  {29'd0, fsq(n, 5), fsq(n, 3), fsq(n, 2)});
            check({tag, "_err"}, n, {31'd0, wr_err}, 32'd0);
        end
    endtask

    initial begin
        // Edge 46..58: ch2 reloaded to 4 on its terminal edge 50.
        add(46, 3'b111, 0, 0, 2'd0, 8'd0, 3'b011, 3'b101, 0);
        add(47, 3'b111, 0, 0, 2'd0, 8'd0, 3'b000, 3'b101, 0);
        add(48, 3'b111, 0, 0, 2'd0, 8'd0, 3'b001, 3'b100, 0);
        add(49, 3'b111, 0, 0, 2'd0, 8'd0, 3'b010, 3'b110, 0);
        add(50, 3'b111, 0, 1, 2'd2, 8'd4, 3'b001, 3'b111, 0);
        add(51, 3'b111, 0, 0, 2'd0, 8'd0, 3'b000, 3'b111, 0);
        add(52, 3'b111, 0, 0, 2'd0, 8'd0, 3'b011, 3'b100, 0);
        add(53, 3'b111, 0, 0, 2'd0, 8'd0, 3'b000, 3'b100, 0);
        add(54, 3'b111, 0, 0, 2'd0, 8'd0, 3'b101, 3'b001, 0);
        add(55, 3'b111, 0, 0, 2'd0, 8'd0, 3'b010, 3'b011, 0);
        add(56, 3'b111, 0, 0, 2'd0, 8'd0, 3'b001, 3'b010, 0);
        add(57, 3'b111, 0, 0, 2'd0, 8'd0, 3'b000, 3'b010, 0);
        add(58, 3'b111, 0, 0, 2'd0, 8'd0, 3'b111, 3'b101, 0);
        // Invalid writes with counting paused (all counters are 0 here).
        add(59, 3'b000, 0, 1, 2'd0, 8'd1, 3'b000, 3'b101, 1);
        add(60, 3'b000, 0, 0, 2'd0, 8'd0, 3'b000, 3'b101, 0);
        add(61, 3'b000, 0, 1, 2'd3, 8'd4, 3'b000, 3'b101, 1);
        add(62, 3'b000, 0, 0, 2'd0, 8'd0, 3'b000, 3'b101, 0);
        // Resume: divisors must still be 2, 3, 4.
        add(63, 3'b111, 0, 0, 2'd0, 8'd0, 3'b000, 3'b101, 0);
        add(64, 3'b111, 0, 0, 2'd0, 8'd0, 3'b001, 3'b100, 0);
        add(65, 3'b111, 0, 0, 2'd0, 8'd0, 3'b010, 3'b110, 0);
        add(66, 3'b111, 0, 0, 2'd0, 8'd0, 3'b101, 3'b011, 0);
        // clr together with ch0 <- 6.
        add(67, 3'b111, 1, 1, 2'd0, 8'd6, 3'b000, 3'b000, 0);
        add(68, 3'b111, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0);
        add(69, 3'b111, 0, 0, 2'd0, 8'd0, 3'b000, 3'b000, 0);
        add(70, 3'b111, 0, 0, 2'd0, 8'd0, 3'b010, 3'b010, 0);
        add(71, 3'b111, 0, 0, 2'd0, 8'd0, 3'b100, 3'b110, 0);
        add(72, 3'b111, 0, 0, 2'd0, 8'd0, 3'b000, 3'b110, 0);
        // First ch0 tick 6 edges after clr; invalid ch write sets wr_err.
        add(73, 3'b111, 0, 1, 2'd3, 8'd9, 3'b011, 3'b101, 1);
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        en      = 3'b000;
        drive_idle();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tick", 0, {29'd0, tick}, 32'd0);
        check("rst_sq",   0, {29'd0, sq},   32'd0);
        check("rst_err",  0, {31'd0, wr_err}, 32'd0);

        // Free run, edges 1..30
        en      = 3'b111;
        reset_n = 1'b1;
        run_free(1, 30, "free");

        // en[1] low for edges 32..35 (cnt[1]=1 after edge 31)
        for (int n = 31; n <= 45; n++) begin
            int  m;
            logic t1;
            @(negedge clk);
            en = (n >= 32 && n <= 35) ? 3'b101 : 3'b111;
            @(posedge clk);
            #1;
            // m = number of counted edges seen by ch1
            m  = (n <= 31) ? n : ((n <= 35) ? 31 : n - 4);
            t1 = (n >= 32 && n <= 35) ? 1'b0 : ftick(m, 3);
            check("gap_tick", n, {29'd0, tick},
                  {29'd0, ftick(n, 5), t1, ftick(n, 2)});
            check("gap_sq", n, {29'd0, sq},
                  {29'd0, fsq(n, 5), fsq(m, 3), fsq(n, 2)});
        end

        // Table-driven writes, invalid writes, clr
        foreach (tbl[k]) begin
            @(negedge clk);
            en     = tbl[k].en;
            clr    = tbl[k].clr;
            wr_en  = tbl[k].wr_en;
            wr_ch  = tbl[k].wr_ch;
            wr_div = tbl[k].wr_div;
            @(posedge clk);
            #1;
            check("tbl_tick", tbl[k].edge_n, {29'd0, tick}, {29'd0, tbl[k].tick});
            check("tbl_sq",   tbl[k].edge_n, {29'd0, sq},   {29'd0, tbl[k].sq});
            check("tbl_err",  tbl[k].edge_n, {31'd0, wr_err}, {31'd0, tbl[k].err});
        end

        // Asynchronous reset between edges while outputs are non-zero
        #3;
        drive_idle();
        reset_n = 1'b0;
        #1;
        check("arst_tick", 0, {29'd0, tick},  32'd0);
        check("arst_sq",   0, {29'd0, sq},    32'd0);
        check("arst_err",  0, {31'd0, wr_err}, 32'd0);
        repeat (2) @(negedge clk);
        en      = 3'b111;
        reset_n = 1'b1;
        // Divisors back to 2, 3, 5
        run_free(1, 12, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
